// File: rtl/snn_report_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snn_report_pkg
//  Purpose  : Shared types and constants for the SNN result reporter:
//             FSM state encoding, ASCII byte constants and the
//             digit-to-ASCII mapping used when formatting a message.
//  Revision : 1.0  initial release
// ============================================================================
package snn_report_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] QMARK = 8'h3F;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    // Digits 0-9 become '0'..'9'; anything the core cannot legally emit
    // is shown as '?' so a corrupted result is visible on the terminal.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        if (d <= 4'd9) begin
            return ZERO + {4'h0, d};
        end
        return QMARK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_result_reporter_if.sv
`default_nettype none
// ============================================================================
//  Module   : snn_result_reporter_if
//  Purpose  : Byte handshake between the result reporter and the UART
//             transmitter.
//  Signals  : tx_rdy   - transmitter idle, able to accept a byte
//             tx_start - one-cycle load pulse for tx_data
//             tx_data  - byte to transmit, held until the next tx_start
//  Modports : master (reporter side), slave (transmitter side)
//  Revision : 1.0  initial release
// ============================================================================
interface snn_result_reporter_if;
    logic       tx_rdy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (input tx_rdy, output tx_start, output tx_data);
    modport slave  (output tx_rdy, input tx_start, input tx_data);
endinterface
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : result_fifo
//  Purpose  : Small synchronous FIFO holding classification results until
//             the reporter FSM is free to format them.
//  Ports    : clk, rst (sync, active high), push/din (write side),
//             pop/dout (read side, dout shows the head combinationally),
//             full, empty.
//  Notes    : DEPTH must be a power of two, minimum 2, so the pointers
//             wrap naturally. A push while full is accepted only when a pop
//             in the same cycle frees the slot.
//  Revision : 1.0  initial release
// ============================================================================
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    // One extra bit so that a full FIFO is distinguishable from an empty one.
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_full_count);
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/snn_result_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : snn_result_reporter
//  Purpose  : Buffers SNN classification results, formats each as ASCII
//             (digit, optionally followed by CR LF) and streams the bytes to
//             the UART transmitter. Also drives the LED status outputs.
//  Ports    : clk, rst          - clock, sync active-high reset
//             done, digit       - result pulse and value from the core
//             tx (master)       - tx_rdy / tx_start / tx_data handshake
//             last_digit        - most recent digit received (LEDs)
//             result_valid      - any result has been accepted
//             overflow          - sticky, a result was dropped (FIFO full)
//             busy              - FIFO non-empty or message in progress
//  Revision : 1.0  initial release
// ============================================================================
module snn_result_reporter
    import snn_report_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit SEND_CRLF  = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              done,
    input  wire logic [3:0]        digit,
    snn_result_reporter_if.master  tx,
    output logic      [3:0]        last_digit,
    output logic                   result_valid,
    output logic                   overflow,
    output logic                   busy
);
    localparam logic [1:0] c_last_idx = SEND_CRLF ? 2'd2 : 2'd0;

    state_t     r_state;
    logic [3:0] r_msg_digit;
    logic [1:0] r_byte_idx;
    logic       r_tx_start;
    logic [7:0] r_tx_data;
    logic [3:0] r_last_digit;
    logic       r_result_valid;
    logic       r_overflow;

    logic       w_fifo_pop;
    logic       w_push_ok;
    logic       w_full;
    logic       w_empty;
    logic [3:0] w_fifo_dout;
    logic [7:0] w_cur_byte;

    assign w_fifo_pop = (r_state == IDLE) && !w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    assign w_push_ok  = !w_full || w_fifo_pop;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (done),
        .pop   (w_fifo_pop),
        .din   (digit),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_cur_byte = digit_to_ascii(r_msg_digit);
        case (r_byte_idx)
            2'd1:    w_cur_byte = CR;
            2'd2:    w_cur_byte = LF;
            default: w_cur_byte = digit_to_ascii(r_msg_digit);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_msg_digit    <= 4'd0;
            r_byte_idx     <= 2'd0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= 8'h00;
            r_last_digit   <= 4'd0;
            r_result_valid <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;

            // The LEDs follow the core even when the FIFO has to drop it.
            if (done) begin
                r_last_digit <= digit;
                if (w_push_ok) begin
                    r_result_valid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_msg_digit <= w_fifo_dout;
                        r_byte_idx  <= 2'd0;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    if (tx.tx_rdy) begin
                        r_tx_data  <= w_cur_byte;
                        r_tx_start <= 1'b1;
                        r_state    <= GUARD;
                    end
                end
                // The transmitter needs a cycle to drop tx_rdy after the
                // load pulse; its stale value is ignored here.
                GUARD: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (tx.tx_rdy) begin
                        if (r_byte_idx == c_last_idx) begin
                            r_state <= IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= SEND;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx.tx_start   = r_tx_start;
    assign tx.tx_data    = r_tx_data;
    assign last_digit    = r_last_digit;
    assign result_valid  = r_result_valid;
    assign overflow      = r_overflow;
    assign busy          = !w_empty || (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_snn_result_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snn_result_reporter
//  Purpose  : Testbench for snn_result_reporter. Instance A sends digit+CR+LF,
//             instance B sends the digit only. Expected bytes are queued by
//             the stimulus and consumed by per-instance monitors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snn_result_reporter;
    import snn_report_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done_a = 1'b0, done_b = 1'b0;
    logic [3:0] digit_a = 4'd0, digit_b = 4'd0;
    logic [3:0] last_a, last_b;
    logic       rv_a, rv_b, ovf_a, ovf_b, busy_a, busy_b;

    snn_result_reporter_if if_a ();
    snn_result_reporter_if if_b ();

    snn_result_reporter #(.FIFO_DEPTH(4), .SEND_CRLF(1'b1)) dut_a (
        .clk(clk), .rst(rst), .done(done_a), .digit(digit_a), .tx(if_a),
        .last_digit(last_a), .result_valid(rv_a), .overflow(ovf_a), .busy(busy_a)
    );

    snn_result_reporter #(.FIFO_DEPTH(4), .SEND_CRLF(1'b0)) dut_b (
        .clk(clk), .rst(rst), .done(done_b), .digit(digit_b), .tx(if_b),
        .last_digit(last_b), .result_valid(rv_b), .overflow(ovf_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Transmitter models: busy for a few cycles after each load pulse.
    logic        hold_a = 1'b0;
    int unsigned cnt_a = 0, cnt_b = 0;
    always @(posedge clk) begin
        if (if_a.tx_start) cnt_a <= 3;
        else if (cnt_a != 0) cnt_a <= cnt_a - 1;
        if (if_b.tx_start) cnt_b <= 3;
        else if (cnt_b != 0) cnt_b <= cnt_b - 1;
    end
    assign if_a.tx_rdy = !hold_a && (cnt_a == 0);
    assign if_b.tx_rdy = (cnt_b == 0);

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int errors = 0;
    int checks = 0;
    int pulses_a = 0, pulses_b = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    // Monitor A
    logic [7:0] last_data_a = 8'h00;
    bit         prev_a = 1'b0;
    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            if (if_a.tx_start) begin
                pulses_a++;
                chk("a_no_back_to_back", {31'd0, prev_a}, 0);
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_byte: got %0h expected none", if_a.tx_data);
                end else begin
                    chk("a_byte", {24'd0, if_a.tx_data}, {24'd0, exp_a.pop_front()});
                end
                last_data_a = if_a.tx_data;
            end else begin
                chk("a_data_stable", {24'd0, if_a.tx_data}, {24'd0, last_data_a});
            end
            prev_a = if_a.tx_start;
            if (rst) last_data_a = 8'h00;
        end
    end

    // Monitor B
    logic [7:0] last_data_b = 8'h00;
    bit         prev_b = 1'b0;
    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            if (if_b.tx_start) begin
                pulses_b++;
                chk("b_no_back_to_back", {31'd0, prev_b}, 0);
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_byte: got %0h expected none", if_b.tx_data);
                end else begin
                    chk("b_byte", {24'd0, if_b.tx_data}, {24'd0, exp_b.pop_front()});
                end
                last_data_b = if_b.tx_data;
            end else begin
                chk("b_data_stable", {24'd0, if_b.tx_data}, {24'd0, last_data_b});
            end
            prev_b = if_b.tx_start;
            if (rst) last_data_b = 8'h00;
        end
    end

    task automatic pulse_a(input logic [3:0] d, input bit expect_sent);
        @(negedge clk);
        done_a = 1'b1; digit_a = d;
        if (expect_sent) begin
            exp_a.push_back(asc(d)); exp_a.push_back(8'h0D); exp_a.push_back(8'h0A);
        end
        @(negedge clk);
        done_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [3:0] d);
        @(negedge clk);
        done_b = 1'b1; digit_b = d;
        exp_b.push_back(asc(d));
        @(negedge clk);
        done_b = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, n >= 2000}, 0);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_tx_start"}, {31'd0, if_a.tx_start}, 0);
        chk({tag, "_tx_data"},  {24'd0, if_a.tx_data}, 0);
        chk({tag, "_last"},     {28'd0, last_a}, 0);
        chk({tag, "_valid"},    {31'd0, rv_a}, 0);
        chk({tag, "_overflow"}, {31'd0, ovf_a}, 0);
        chk({tag, "_busy"},     {31'd0, busy_a}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int p0;

        // Reset values
        repeat (3) @(negedge clk);
        chk_reset_a("reset");
        chk("reset_b_busy", {31'd0, busy_b}, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Digit 7 with CR LF, latency from done to first tx_start
        pulse_a(4'd7, 1'b1);
        lat = 1;
        while (!if_a.tx_start && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 3);
        drain("drain_7");
        chk("last_digit_7", {28'd0, last_a}, 7);
        chk("result_valid_7", {31'd0, rv_a}, 1);
        chk("busy_after_7", {31'd0, busy_a}, 0);

        // Digit 12, digit-only message: a single '?' byte
        pulse_b(4'd12);
        drain("drain_12");
        chk("b_pulse_count", pulses_b, 1);
        chk("b_last_digit", {28'd0, last_b}, 12);

        // FSM occupied by digit 9, then burst 1..5 overflows the FIFO
        hold_a = 1'b1;
        pulse_a(4'd9, 1'b1);
        for (int d = 1; d <= 5; d++) begin
            if (d == 5) chk("overflow_before_drop", {31'd0, ovf_a}, 0);
            pulse_a(4'(d), d <= 4);
        end
        chk("overflow_set", {31'd0, ovf_a}, 1);
        hold_a = 1'b0;
        drain("drain_burst");
        chk("overflow_sticky", {31'd0, ovf_a}, 1);
        chk("last_digit_dropped", {28'd0, last_a}, 5);

        // Push into a full FIFO coinciding with an IDLE pop
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("overflow_cleared", {31'd0, ovf_a}, 0);
        hold_a = 1'b1;
        pulse_a(4'd4, 1'b1);
        pulse_a(4'd10, 1'b1);
        pulse_a(4'd11, 1'b1);
        pulse_a(4'd3, 1'b1);
        pulse_a(4'd6, 1'b1);
        hold_a = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dut_a.r_state != IDLE && n < 200);
        chk("idle_reached", {31'd0, n >= 200}, 0);
        done_a = 1'b1; digit_a = 4'd8;
        exp_a.push_back(asc(4'd8)); exp_a.push_back(8'h0D); exp_a.push_back(8'h0A);
        @(negedge clk);
        done_a = 1'b0;
        drain("drain_full_pop");
        chk("no_overflow_on_pop", {31'd0, ovf_a}, 0);

        // Reset in the middle of a message
        pulse_a(4'd5, 1'b1);
        n = 0;
        while (!if_a.tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_first_byte_seen", {31'd0, n >= 50}, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_a.delete();
        @(negedge clk);
        chk_reset_a("midrst");
        rst = 1'b0;
        p0 = pulses_a;
        repeat (10) @(negedge clk);
        chk("no_bytes_after_rst", pulses_a - p0, 0);
        pulse_a(4'd2, 1'b1);
        drain("drain_after_rst");

        // tx_rdy held low for 500 cycles while in SEND
        hold_a = 1'b1;
        pulse_a(4'd8, 1'b1);
        p0 = pulses_a;
        repeat (500) @(negedge clk);
        chk("hold_no_pulse", pulses_a - p0, 0);
        hold_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("release_one_pulse", pulses_a - p0, 1);
        drain("drain_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
